scmp_useq: RTL and testbench
============================

// Module: scmp_useq
// PURPOSE
//  Parametrised microcode sequencer; the next generation of the single-level-return SC/MP sequencer.
//  Computes the microcode PC each cycle from the current microword fields, the opcode-decode target and condition inputs.
//  Adds a bounded return stack, a bus-wait stall, and an interrupt dispatch hook at the decode point.
//  Sits between the microcode PLA (consumes its fields, drives its PC) and the bus/register datapath.
// PARAMETERS
//  PC_W      8     microcode PC width; next-offset field is also PC_W bits, added modulo 2**PC_W
//  COND_W    6     width of condition vector / cond_mask / cond_xor
//  STK_DEPTH 4     return stack entries (>=1; 1 reproduces legacy single mc_ret)
//  IRQ_VEC   8'hF0 microcode PC taken on interrupt dispatch (PC_W bits)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous, active-low reset
//  stall      in   1       bus not ready; freezes all sequencer state this cycle
//  mc_next    in   PC_W    microword next-offset field; 0 means "go to PC 0 (fetch)"
//  mc_cmask   in   COND_W  microword condition mask
//  mc_cxor    in   COND_W  microword condition polarity
//  mc_decode  in   1       microword ctl: dispatch to dec_pc
//  mc_call    in   1       microword ctl: push mc_pc+1
//  mc_ret     in   1       microword ctl: pop return address into PC
//  mc_irqchk  in   1       microword ctl: decode point may be pre-empted by interrupt
//  dec_pc     in   PC_W    opcode-to-microPC mapping result
//  cond_in    in   COND_W  live condition inputs (op bits, jump test, post-inc, ...)
//  irq_req    in   1       level interrupt request (already synchronised)
//  irq_en     in   1       interrupt enable (IE flag)
//  err_clr    in   1       clears sticky error flags
//  mc_pc      out  PC_W    current microcode PC (to PLA)
//  irq_ack    out  1       one-cycle pulse when interrupt dispatch taken
//  stk_ovf    out  1       sticky: push while stack full
//  stk_unf    out  1       sticky: pop while stack empty
// BEHAVIOUR
//  Reset: mc_pc=0, stack pointer=0 (empty), all entries=0, irq_ack=0, stk_ovf=0, stk_unf=0; async assert, sync to clk edge on release.
//  cond = |((cond_in ^ mc_cxor) & mc_cmask); combinational from current microword.
//  stall=1: mc_pc, stack, sp, flags hold; irq_ack=0; no push/pop. err_clr is still honoured under stall.
//  Next-PC priority (stall=0), one update per cycle, zero added latency:
//   1. mc_irqchk & mc_decode & irq_req & irq_en -> IRQ_VEC, irq_ack=1 next cycle only.
//   2. mc_decode                                 -> dec_pc
//   3. mc_ret                                    -> top of stack (pop); if empty -> 0, set stk_unf
//   4. cond                                      -> mc_pc+1
//   5. mc_next==0                                -> 0
//   6. otherwise                                 -> mc_pc+mc_next (mod 2**PC_W; wraps, so large offsets branch backwards)
//  Push: mc_call & ~stall pushes mc_pc+1 (mod 2**PC_W), independent of which next-PC source wins.
//  Full stack + push: oldest entry discarded (circular), sp saturates at STK_DEPTH, stk_ovf set.
//  Call+ret same cycle: pop value used as next PC, pushed value replaces it (sp unchanged); no ovf/unf unless stack empty (unf set, PC=0, push still occurs).
//  Ret ignored (no pop) when decode/irq wins priority.
//  err_clr & simultaneous new error: the error wins (flag stays set).
//  Reset mid-sequence: all state returns to reset values immediately; stack contents discarded.
// STRUCTURE
//  scmp_microcode_pak: add USEQ_CTL_t (decode/call/ret/irqchk bit indices), default IRQ_VEC constant.
//  Sub-module scmp_useq_stack: parametrised circular LIFO (push, pop, top, empty, full, ovf/unf pulses).
//  Top: cond reduction, next-PC priority mux, irq_ack register, sticky flags.
// TESTING
//  Reset with stall=0 -> mc_pc=0, flags 0, irq_ack 0; hold 3 cycles with mc_next=0 -> mc_pc stays 0.
//  mc_next=3 at PC 0x10 -> 0x13; mc_next=8'hFE at 0x13 -> 0x11; mc_next=2 at 0xFF -> 0x01 (wrap).
//  cmask=6'b000010, cxor=0, cond_in[1]=1 -> PC+1 regardless of mc_next=5; cxor[1]=1 -> PC+5.
//  Nested calls at 0x20,0x30,0x40,0x50 (DEPTH=4) then 4 rets -> 0x51,0x41,0x31,0x21; 5th call sets stk_ovf; ret on empty -> PC=0, stk_unf=1.
//  Decode with irqchk, irq_req=1, irq_en=1 -> PC=IRQ_VEC, irq_ack high exactly 1 cycle; irq_en=0 -> PC=dec_pc, no ack.
//  stall=1 for 4 cycles during call with mc_next=7 -> PC, sp unchanged, no push; release -> push and branch occur once.

Source files
------------

// File: rtl/scmp_useq_pkg.sv
// Shared definitions for the SC/MP microcode sequencer.
package scmp_useq_pkg;

    // Bit positions of the microword control group.
    typedef enum int unsigned {
        CTL_DECODE = 0,
        CTL_CALL   = 1,
        CTL_RET    = 2,
        CTL_IRQCHK = 3
    } useq_ctl_t;

    localparam int unsigned USEQ_CTL_W = 4;

    // Default interrupt dispatch entry point in microcode space.
    localparam logic [7:0] USEQ_IRQ_VEC_DFLT = 8'hF0;

    // Which source supplied the next microcode PC.
    typedef enum logic [2:0] {
        SRC_IRQ  = 3'd0,
        SRC_DEC  = 3'd1,
        SRC_RET  = 3'd2,
        SRC_INC  = 3'd3,
        SRC_ZERO = 3'd4,
        SRC_OFS  = 3'd5
    } pc_src_t;

endpackage

// File: rtl/scmp_useq_stack.sv
// Circular return-address LIFO. A push onto a full stack overwrites the
// oldest entry; push and pop together replace the top entry in place.
module scmp_useq_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         ovf_o,
    output logic         unf_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [IW-1:0] wp_q, wp_d, wp_inc, wp_dec;
    logic [CW-1:0] sp_q, sp_d;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    // Pointer arithmetic, top-of-stack read and next-state for push/pop.
    always_comb begin
        wp_inc  = (wp_q == IW'(DEPTH - 1)) ? '0 : wp_q + IW'(1);
        wp_dec  = (wp_q == '0) ? IW'(DEPTH - 1) : wp_q - IW'(1);
        empty_o = (sp_q == '0);
        full_o  = (sp_q == CW'(DEPTH));
        top_o   = mem_q[wp_dec];
        ovf_o   = push_i & ~pop_i & full_o;
        unf_o   = pop_i & empty_o;
        wp_d    = wp_q;
        sp_d    = sp_q;
        wr_en   = 1'b0;
        wr_idx  = wp_q;
        if (push_i && pop_i && !empty_o) begin
            // Return address is consumed and replaced by the new one.
            wr_en  = 1'b1;
            wr_idx = wp_dec;
        end else if (pop_i && !empty_o) begin
            wp_d = wp_dec;
            sp_d = sp_q - CW'(1);
        end else if (push_i) begin
            // Also covers push together with a pop on an empty stack.
            wr_en = 1'b1;
            wp_d  = wp_inc;
            if (!full_o) sp_d = sp_q + CW'(1);
        end
    end

    // Stack storage and pointers; contents are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q <= wp_d;
            sp_q <= sp_d;
            if (wr_en) mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/scmp_useq.sv
// Microcode sequencer: condition reduction, next-PC priority selection,
// return stack, interrupt dispatch acknowledge and sticky stack errors.
module scmp_useq
    import scmp_useq_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              COND_W    = 6,
    parameter int              STK_DEPTH = 4,
    parameter logic [PC_W-1:0] IRQ_VEC   = PC_W'(USEQ_IRQ_VEC_DFLT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [PC_W-1:0]   mc_next,
    input  logic [COND_W-1:0] mc_cmask,
    input  logic [COND_W-1:0] mc_cxor,
    input  logic              mc_decode,
    input  logic              mc_call,
    input  logic              mc_ret,
    input  logic              mc_irqchk,
    input  logic [PC_W-1:0]   dec_pc,
    input  logic [COND_W-1:0] cond_in,
    input  logic              irq_req,
    input  logic              irq_en,
    input  logic              err_clr,
    output logic [PC_W-1:0]   mc_pc,
    output logic              irq_ack,
    output logic              stk_ovf,
    output logic              stk_unf
);
    logic [USEQ_CTL_W-1:0] ctl;
    logic [PC_W-1:0]       pc_q, pc_d, pc_inc, stk_top;
    logic                  cond, irq_take, push, pop;
    logic                  stk_empty, stk_full, ovf_p, unf_p;
    logic                  irq_ack_q, ovf_q, ovf_d, unf_q, unf_d;
    pc_src_t               src;

    scmp_useq_stack #(.W(PC_W), .DEPTH(STK_DEPTH)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .empty_o (stk_empty),
        .full_o  (stk_full),
        .ovf_o   (ovf_p),
        .unf_o   (unf_p)
    );

    // Next-PC priority mux; a stall freezes the PC and suppresses stack ops.
    always_comb begin
        ctl              = '0;
        ctl[CTL_DECODE]  = mc_decode;
        ctl[CTL_CALL]    = mc_call;
        ctl[CTL_RET]     = mc_ret;
        ctl[CTL_IRQCHK]  = mc_irqchk;
        cond     = |((cond_in ^ mc_cxor) & mc_cmask);
        pc_inc   = pc_q + PC_W'(1);
        irq_take = 1'b0;
        pop      = 1'b0;
        push     = ctl[CTL_CALL];
        if (ctl[CTL_IRQCHK] && ctl[CTL_DECODE] && irq_req && irq_en) begin
            src      = SRC_IRQ;
            irq_take = 1'b1;
        end else if (ctl[CTL_DECODE]) begin
            src = SRC_DEC;
        end else if (ctl[CTL_RET]) begin
            src = SRC_RET;
            pop = 1'b1;
        end else if (cond) begin
            src = SRC_INC;
        end else if (mc_next == '0) begin
            src = SRC_ZERO;
        end else begin
            src = SRC_OFS;
        end
        case (src)
            SRC_IRQ:  pc_d = IRQ_VEC;
            SRC_DEC:  pc_d = dec_pc;
            SRC_RET:  pc_d = stk_empty ? '0 : stk_top;
            SRC_INC:  pc_d = pc_inc;
            SRC_ZERO: pc_d = '0;
            default:  pc_d = pc_q + mc_next;
        endcase
        if (stall) begin
            pc_d     = pc_q;
            push     = 1'b0;
            pop      = 1'b0;
            irq_take = 1'b0;
        end
        // A new error in the same cycle as err_clr keeps the flag set.
        ovf_d = (ovf_q & ~err_clr) | ovf_p;
        unf_d = (unf_q & ~err_clr) | unf_p;
    end

    // PC, interrupt acknowledge pulse and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            irq_ack_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            irq_ack_q <= irq_take;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign mc_pc   = pc_q;
    assign irq_ack = irq_ack_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

    // Full flag is only consumed inside the stack; keep it observable here.
    logic unused_full;
    assign unused_full = stk_full;

endmodule

// File: tb/tb_scmp_useq.sv
// Directed bench for scmp_useq (PC_W=8, COND_W=6, STK_DEPTH=4, IRQ_VEC=F0).
module tb_scmp_useq;
    logic       clk = 1'b0;
    logic       rst_n, stall, err_clr;
    logic [7:0] mc_next, dec_pc, mc_pc;
    logic [5:0] mc_cmask, mc_cxor, cond_in;
    logic       mc_decode, mc_call, mc_ret, mc_irqchk, irq_req, irq_en;
    logic       irq_ack, stk_ovf, stk_unf;

    int n_checks = 0;
    int n_errors = 0;

    scmp_useq dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .mc_next(mc_next),
        .mc_cmask(mc_cmask), .mc_cxor(mc_cxor), .mc_decode(mc_decode),
        .mc_call(mc_call), .mc_ret(mc_ret), .mc_irqchk(mc_irqchk),
        .dec_pc(dec_pc), .cond_in(cond_in), .irq_req(irq_req),
        .irq_en(irq_en), .err_clr(err_clr), .mc_pc(mc_pc),
        .irq_ack(irq_ack), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    // Clock
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Neutral microword
    task automatic idle();
        stall = 0; err_clr = 0; mc_next = 8'h00; dec_pc = 8'h00;
        mc_cmask = '0; mc_cxor = '0; cond_in = '0;
        mc_decode = 0; mc_call = 0; mc_ret = 0; mc_irqchk = 0;
        irq_req = 0; irq_en = 0;
    endtask

    task automatic go_dec(input logic [7:0] target, input logic call);
        idle(); mc_decode = 1; dec_pc = target; mc_call = call; tick();
    endtask

    task automatic do_ret();
        idle(); mc_ret = 1; tick();
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick(); tick();
        check("rst_pc", mc_pc, 8'h00);
        check("rst_ack", irq_ack, 1'b0);
        check("rst_ovf", stk_ovf, 1'b0);
        check("rst_unf", stk_unf, 1'b0);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_pc", mc_pc, 8'h00);
        end

        // Offset branching and wrap
        go_dec(8'h10, 0);           check("dec_10", mc_pc, 8'h10);
        idle(); mc_next = 8'h03; tick(); check("ofs_p3", mc_pc, 8'h13);
        idle(); mc_next = 8'hFE; tick(); check("ofs_m2", mc_pc, 8'h11);
        go_dec(8'hFF, 0);           check("dec_ff", mc_pc, 8'hFF);
        idle(); mc_next = 8'h02; tick(); check("ofs_wrap", mc_pc, 8'h01);

        // Condition reduction
        idle(); mc_cmask = 6'b000010; cond_in = 6'b000010; mc_next = 8'h05;
        tick(); check("cond_true", mc_pc, 8'h02);
        mc_cxor = 6'b000010;
        tick(); check("cond_xor", mc_pc, 8'h07);
        idle(); tick(); check("next0", mc_pc, 8'h00);

        // Nested calls then returns
        go_dec(8'h20, 0);
        go_dec(8'h30, 1);
        go_dec(8'h40, 1);
        go_dec(8'h50, 1);
        go_dec(8'h60, 1);           check("call4_pc", mc_pc, 8'h60);
        check("call4_ovf", stk_ovf, 1'b0);
        do_ret(); check("ret1", mc_pc, 8'h51);
        do_ret(); check("ret2", mc_pc, 8'h41);
        do_ret(); check("ret3", mc_pc, 8'h31);
        do_ret(); check("ret4", mc_pc, 8'h21);
        check("ret4_unf", stk_unf, 1'b0);
        do_ret(); check("ret_empty_pc", mc_pc, 8'h00);
        check("ret_empty_unf", stk_unf, 1'b1);
        idle(); err_clr = 1; tick(); check("clr_unf", stk_unf, 1'b0);

        // Overflow: oldest entry (0x01) is discarded
        go_dec(8'h20, 1);
        go_dec(8'h30, 1);
        go_dec(8'h40, 1);
        go_dec(8'h50, 1);           check("full_no_ovf", stk_ovf, 1'b0);
        go_dec(8'h60, 1);           check("ovf_set", stk_ovf, 1'b1);
        do_ret(); check("ovret1", mc_pc, 8'h51);
        do_ret(); check("ovret2", mc_pc, 8'h41);
        do_ret(); check("ovret3", mc_pc, 8'h31);
        do_ret(); check("ovret4", mc_pc, 8'h21);
        check("ovret_unf", stk_unf, 1'b0);
        idle(); mc_ret = 1; err_clr = 1; tick();
        check("clr_vs_err_pc", mc_pc, 8'h00);
        check("clr_vs_err_unf", stk_unf, 1'b1);
        check("clr_ovf", stk_ovf, 1'b0);
        idle(); err_clr = 1; tick(); check("clr_unf2", stk_unf, 1'b0);

        // Interrupt dispatch
        idle(); mc_decode = 1; mc_irqchk = 1; dec_pc = 8'h33; irq_req = 1; irq_en = 1;
        tick(); check("irq_pc", mc_pc, 8'hF0); check("irq_ack_hi", irq_ack, 1'b1);
        idle(); tick(); check("irq_ack_lo", irq_ack, 1'b0);
        idle(); mc_decode = 1; mc_irqchk = 1; dec_pc = 8'h33; irq_req = 1; irq_en = 0;
        tick(); check("irq_dis_pc", mc_pc, 8'h33); check("irq_dis_ack", irq_ack, 1'b0);

        // Ret ignored when decode wins
        idle(); mc_call = 1; tick(); check("call_next0", mc_pc, 8'h00);
        idle(); mc_decode = 1; mc_ret = 1; dec_pc = 8'h44; tick();
        check("dec_over_ret", mc_pc, 8'h44);
        do_ret(); check("ret_kept", mc_pc, 8'h34);

        // Stall during call + branch
        idle(); mc_call = 1; mc_next = 8'h07; stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); check("stall_pc", mc_pc, 8'h34);
        end
        stall = 0; tick(); check("unstall_pc", mc_pc, 8'h3B);
        do_ret(); check("unstall_ret", mc_pc, 8'h35);
        check("unstall_unf", stk_unf, 1'b0);
        do_ret(); check("single_push_pc", mc_pc, 8'h00);
        check("single_push_unf", stk_unf, 1'b1);
        idle(); stall = 1; err_clr = 1; tick(); check("stall_clr", stk_unf, 1'b0);

        // Call and ret in the same cycle
        go_dec(8'h60, 1);
        idle(); mc_call = 1; mc_ret = 1; tick(); check("callret_pc", mc_pc, 8'h01);
        do_ret(); check("callret_top", mc_pc, 8'h61);
        check("callret_unf", stk_unf, 1'b0);
        do_ret(); check("callret_empty", stk_unf, 1'b1);

        // Reset mid-sequence discards the stack
        go_dec(8'h70, 1); check("pre_rst_pc", mc_pc, 8'h70);
        rst_n = 0; #1;
        check("async_rst_pc", mc_pc, 8'h00);
        check("async_rst_unf", stk_unf, 1'b0);
        tick(); rst_n = 1;
        do_ret(); check("post_rst_ret", mc_pc, 8'h00);
        check("post_rst_unf", stk_unf, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL timeout: run did not finish, expected completion");
        $fatal(1);
    end

endmodule
